fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline; acts on the jump and stall requests raised by the hazard logic.
- Owns the PC register and drives a synchronous instruction memory.
- Loads the IF/ID pipeline register and inserts NOP bubbles on jump redirects.
- Holds the PC and IF/ID contents while ID is stalled, and counts the bubbles it inserts.

Parameters:
- PC_WIDTH, 32, width of the PC and all addresses.
- INSTR_WIDTH, 32, width of an instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID for a bubble.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset; deassertion synchronous to clk is handled by the top level.
- stall_id  in  1  hold PC and IF/ID this cycle.
- jump_valid  in  1  redirect fetch this cycle; also kills IF/ID.
- jump_target  in  PC_WIDTH  redirect address, sampled when jump_valid=1.
- imem_addr  out  PC_WIDTH  fetch address, equal to the PC register.
- imem_en  out  1  read enable. Memory returns data on imem_rdata one cycle after an enabled read and holds its output while imem_en=0.
- imem_rdata  in  INSTR_WIDTH  read data from instruction memory.
- if_id_instr  out  INSTR_WIDTH  IF/ID instruction.
- if_id_pc4  out  PC_WIDTH  IF/ID PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- bubble_cnt  out  CNT_WIDTH  saturating count of inserted bubbles.
- align_err  out  1  sticky: a jump target had bits [1:0] != 0.

Behaviour:

Reset (asynchronous, reset_n=0):
- pc=RESET_PC, fetch_pc_q=RESET_PC, FSM=FILL.
- if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
- bubble_cnt=0, align_err=0.
- Asserting reset mid-operation discards any in-flight fetch.

FSM (two states):
- FILL: no valid word is in flight.
- RUN: imem_rdata will carry the word at fetch_pc_q.

Combinational outputs:
- imem_addr=pc.
- imem_en = !stall_id && !jump_valid.

Per-cycle priority: jump_valid > stall_id > normal.

Jump (jump_valid=1, stall_id ignored):
- pc <= {jump_target[PC_WIDTH-1:2], 2'b00}.
- FSM <= FILL.
- if_id_instr <= NOP_INSTR, if_id_valid <= 0; if_id_pc4 holds.
- bubble_cnt increments.
- align_err <= 1 if jump_target[1:0] != 0.

Stall (stall_id=1, jump_valid=0):
- pc, fetch_pc_q, FSM and all IF/ID fields hold; bubble_cnt holds.

Normal:
- FILL: IF/ID <= {NOP_INSTR, valid=0}; bubble_cnt increments.
- RUN: if_id_instr <= imem_rdata, if_id_pc4 <= fetch_pc_q+4, if_id_valid <= 1.
- In both states: fetch_pc_q <= pc, pc <= pc+4, FSM <= RUN.

Arithmetic:
- PC increments wrap modulo 2^PC_WIDTH; no overflow flag.
- bubble_cnt saturates at all-ones and never wraps.

Latency:
- First instruction is valid in IF/ID at the 2nd rising edge after reset release, provided there is no stall.
- A jump accepted at edge T gives 2 bubbles; the target instruction is valid in IF/ID after edge T+2 (plus any stall cycles in between).
- Back-to-back jumps: the last one wins, and each jump cycle counts as one bubble.

Test Plan:
- Reset, then 4 free cycles with imem[0..3]=A,B,C,D -> IF/ID valid=0,1,1,1 carrying NOP,A,B,C; if_id_pc4=4,8,12; bubble_cnt=1.
- Run to pc=0x10, then stall_id=1 for 3 cycles -> imem_en=0; imem_addr=0x10 constant; IF/ID unchanged; bubble_cnt unchanged. After release, the sequence continues with no lost or duplicated instruction.
- jump_valid=1 with target=0x100 at pc=0x20 -> next edge IF/ID valid=0 with imem_addr=0x100; then one more bubble; then if_id_instr=imem[0x100], if_id_pc4=0x104; bubble_cnt increases by 2.
- jump_valid=1 and stall_id=1 in the same cycle with target=0x40 -> jump taken; IF/ID killed; pc=0x40.
- jump_target=0x102 -> pc=0x100, align_err=1, still 1 after 10 more cycles; cleared only by reset_n=0.
- CNT_WIDTH=4 with 20 consecutive jumps -> bubble_cnt=15 and holds. Assert reset_n=0 mid-run -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC register, synchronous imem port, IF/ID register.
// Jumps kill IF/ID and refill; stalls freeze PC and IF/ID.
module fetch_redirect_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall_id,
  input  logic                   jump_valid,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc4,
  output logic                   if_id_valid,
  output logic [CNT_WIDTH-1:0]   bubble_cnt,
  output logic                   align_err
);

  typedef enum logic {FILL, RUN} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [PC_WIDTH-1:0]    pc4_d;
  logic                   valid_d;
  logic                   bub_inc;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   align_d;

  assign imem_addr = pc_q;
  assign imem_en   = !stall_id && !jump_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = if_id_instr;
    pc4_d      = if_id_pc4;
    valid_d    = if_id_valid;
    bub_inc    = 1'b0;
    align_d    = align_err;
    unique case (1'b1)
      jump_valid: begin
        pc_d    = {jump_target[PC_WIDTH-1:2], 2'b00};
        state_d = FILL;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        bub_inc = 1'b1;
        if (jump_target[1:0] != 2'b00) align_d = 1'b1;
      end
      (!jump_valid && stall_id): begin
      end
      default: begin
        if (state_q == RUN) begin
          instr_d = imem_rdata;
          pc4_d   = fetch_pc_q + PC_WIDTH'(4);
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          bub_inc = 1'b1;
        end
        fetch_pc_d = pc_q;
        pc_d       = pc_q + PC_WIDTH'(4);
        state_d    = RUN;
      end
    endcase
  end

  // saturate instead of wrapping
  always_comb begin
    cnt_d = bubble_cnt;
    if (bub_inc && bubble_cnt != {CNT_WIDTH{1'b1}})
      cnt_d = bubble_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      bubble_cnt  <= '0;
      align_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      if_id_instr <= instr_d;
      if_id_pc4   <= pc4_d;
      if_id_valid <= valid_d;
      bubble_cnt  <= cnt_d;
      align_err   <= align_d;
    end
  end

endmodule
